// File: rtl/step_run_ctrl.sv
// Step/run clock-enable generator for the pipeline core: debounced single-step, periodic run.
// Optional macro BREAKPOINT_EN enables auto-halt in run mode when pc matches bp_addr.
module step_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_step,
    input  logic             sw_run,
    input  logic [15:0]      pc,
    input  logic [15:0]      bp_addr,
    output logic             step_en,
    output logic [CNT_W-1:0] step_count,
    output logic             run_led,
    output logic             bp_hit
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(RUN_DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        WAIT_REL,
        RUN,
        BP_HALT
    } state_t;

    state_t           state;
    logic [1:0]       key_sync;
    logic [1:0]       run_sync;
    logic             key_s;
    logic             run_s;
    logic             key_db;
    logic [DB_W-1:0]  db_cnt;
    logic             press;
    logic [DIV_W-1:0] div;

    assign key_s = key_sync[1];
    assign run_s = run_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_sync <= 2'b11;
            run_sync <= 2'b00;
        end else begin
            key_sync <= {key_sync[0], key_step};
            run_sync <= {run_sync[0], sw_run};
        end
    end

    // press is a one-cycle flag raised on the same edge the debounced key falls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_db <= 1'b1;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_s != key_db) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_db <= key_s;
                    db_cnt <= '0;
                    press  <= ~key_s;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

`ifdef BREAKPOINT_EN
    // pc reflects the advanced instruction one cycle after the pulse
    logic stepped;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stepped <= 1'b0;
        end else begin
            stepped <= step_en;
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            div        <= '0;
            step_en    <= 1'b0;
            step_count <= '0;
            run_led    <= 1'b0;
            bp_hit     <= 1'b0;
        end else begin
            step_en    <= 1'b0;
            step_count <= step_count + CNT_W'(step_en);
            unique case (state)
                IDLE: begin
                    if (press) begin
                        state   <= STEP;
                        step_en <= 1'b1;
                    end else if (run_s) begin
                        state   <= RUN;
                        div     <= '0;
                        run_led <= 1'b1;
                    end
                end
                STEP: begin
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (key_db) begin
                        state   <= run_s ? RUN : IDLE;
                        div     <= '0;
                        run_led <= run_s;
                    end
                end
                RUN: begin
                    if (!run_s) begin
                        state   <= IDLE;
                        div     <= '0;
                        run_led <= 1'b0;
`ifdef BREAKPOINT_EN
                    end else if (stepped && pc == bp_addr) begin
                        state   <= BP_HALT;
                        div     <= '0;
                        run_led <= 1'b0;
                        bp_hit  <= 1'b1;
`endif
                    end else if (div == DIV_W'(RUN_DIV - 1)) begin
                        div     <= '0;
                        step_en <= 1'b1;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                BP_HALT: begin
                    if (!run_s) begin
                        state  <= IDLE;
                        bp_hit <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    run_led <= 1'b0;
                    bp_hit  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/step_run_ctrl.md
Name: step_run_ctrl

Overview:
- Clock-enable generator placed directly upstream of the pipeline core on the DE2 board. It replaces driving the core clock from a raw push-button.
- Debounces the step key and produces single-cycle step_en pulses, either one per key press or periodically in run mode. The core gates every pipeline register with step_en.
- Maintains a step counter for the seven-segment display. Run mode can auto-halt on a PC breakpoint.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required before a key level is accepted (10 ms at 50 MHz)
RUN_DIV, 25000000, clk cycles between step_en pulses in run mode (2 Hz); legal range >= 1
CNT_W, 16, width of step_count

Ports:
clk  input  1  CLOCK_50 domain clock
rst  input  1  asynchronous, active-low reset (wired directly from KEY[3])
key_step  input  1  raw push-button, active-low (KEY[1]), asynchronous
sw_run  input  1  raw slide switch, 1 = run mode, asynchronous
pc  input  16  core PC; used only with BREAKPOINT_EN
bp_addr  input  16  breakpoint address from switches; used only with BREAKPOINT_EN
step_en  output  1  one-clk-cycle advance pulse to the core
step_count  output  CNT_W  number of step_en pulses issued since reset
run_led  output  1  1 while in RUN state
bp_hit  output  1  1 while in BP_HALT state (always 0 without BREAKPOINT_EN)

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: step_en=0, step_count=0, run_led=0, bp_hit=0.
  - State: state=IDLE, divider=0, debounced key=released (1), debounce counter=0, synchronizers=1 (key) / 0 (run).
  - Reset asserted mid-pulse or mid-division clears everything immediately. No pulse is issued on reset release.
- Synchronizers: key_step and sw_run each pass through 2 flops before any use.
- Debounce (key only):
  - While the synced key differs from the debounced key, a counter increments; any reversion clears it.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced key takes the new level and the counter clears.
  - Press = debounced key falling 1->0.
- Press latency: with key held low from cycle t, step_en is high exactly in cycle t+DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES + 1 FSM).
- sw_run is not debounced: the switch level is used after synchronization only.
- FSM states: IDLE, STEP, WAIT_REL, RUN, BP_HALT.
  - IDLE: press -> STEP. Else synced run=1 -> RUN.
  - STEP: step_en=1 for exactly this one cycle -> WAIT_REL.
  - WAIT_REL: stay until debounced key=1. Then -> RUN if synced run=1, else IDLE.
    - Holding the key never produces a second pulse.
  - RUN: divider counts 0..RUN_DIV-1.
    - At RUN_DIV-1: step_en=1 and divider wraps to 0. First pulse is RUN_DIV cycles after entering RUN.
    - RUN_DIV=1: pulse every cycle.
    - Key presses are ignored.
    - Synced run=0 -> IDLE, divider cleared in the same transition, no pulse issued that cycle.
  - BP_HALT: step_en=0, bp_hit=1. Leaves only when synced run=0 -> IDLE.
- step_count: increments by 1 in every cycle step_en=1. Wraps from 2^CNT_W-1 to 0 with no flag.
- All outputs are registered. run_led = (state==RUN).

Optional Feature:
- Macro: BREAKPOINT_EN.
- Defined:
  - In RUN, on the cycle after a step_en pulse, if pc == bp_addr, go to BP_HALT. The instruction at bp_addr has been fetched but is not advanced further.
  - The check happens only after a step, so entering RUN with pc already equal to bp_addr still issues one pulse before halting.
  - Single-step mode ignores breakpoints.
- Undefined: pc and bp_addr are unused, BP_HALT is unreachable, bp_hit is tied to 0.

Test Plan:
- DEBOUNCE_CYCLES=4, RUN_DIV=5. Hold key_step=0 from cycle 10 for 40 cycles -> single step_en pulse in cycle 17, step_count=1, no further pulses until release.
- Bounce: key toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> no step_en, step_count stays 0.
- sw_run=1 from cycle 0 after reset release -> RUN entered in cycle 3, step_en in cycles 8,13,18,...; set sw_run=0 -> pulses stop within 3 cycles, run_led=0.
- CNT_W=4, 17 presses -> step_count reads 1 after the 17th.
- Reset asserted in the cycle step_en=1 during RUN -> step_en and step_count are 0 immediately. After release with sw_run=1, the first pulse is 5 cycles after re-entering RUN.
- BREAKPOINT_EN, bp_addr=0x0003, pc increments on each step_en starting from 0 -> exactly 3 pulses, then bp_hit=1 with step_en held 0. sw_run=0 -> IDLE, bp_hit=0.
